// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point arithmetic units.
package fixed_point_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  // Two's complement overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtract_digit_subtract.sv
// Combinational K-bit digit subtractor: {bo, d} = a - b - bi.
module digit_subtract #(
  parameter int K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         bi,
  output logic [K-1:0] d,
  output logic         bo
);

  logic [K:0] w_diff;

  // The K+1-bit result is negative exactly when a borrow is needed, so its top bit is the borrow.
  assign w_diff = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, bi};
  assign d      = w_diff[K-1:0];
  assign bo     = w_diff[K];

endmodule

// File: rtl/serial_subtract.sv
// Digit-serial subtractor c = a - b - bi, K bits per cycle, LSB digit first, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit per cycle, D cycles
// DONE  | result presented, out_valid=1 until out_ready
module serial_subtract
  import fixed_point_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         bo,
  output logic         ov
);

  localparam int D  = N / K;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  generate
    if (N % K != 0) begin : g_bad_width
      $error("serial_subtract: N must be a multiple of K");
    end
  endgenerate

  sub_state_t      r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;
  logic [N-1:0]    r_c;
  logic            r_borrow;
  logic            r_bo;
  logic            r_ov;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [IW-1:0]   r_idx;

  logic [K-1:0]    w_a_dig;
  logic [K-1:0]    w_b_dig;
  logic [K-1:0]    w_d;
  logic            w_bo;
  logic            w_last;
  logic [N-1:0]    w_res_next;

  assign w_a_dig = r_a[int'(r_idx)*K +: K];
  assign w_b_dig = r_b[int'(r_idx)*K +: K];
  assign w_last  = (r_idx == IW'(D - 1));

  digit_subtract #(.K(K)) u_digit (
    .a  (w_a_dig),
    .b  (w_b_dig),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Partial result with the current digit merged in; on the last digit this is the full difference.
  always_comb begin
    w_res_next = r_res;
    w_res_next[int'(r_idx)*K +: K] = w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_c         <= '0;
      r_borrow    <= 1'b0;
      r_bo        <= 1'b0;
      r_ov        <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bi;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_res    <= w_res_next;
          r_borrow <= w_bo;
          r_idx    <= r_idx + 1'b1;
          if (w_last) begin
            r_c         <= w_res_next;
            r_bo        <= w_bo;
            r_ov        <= sub_overflow(r_a[N-1], r_b[N-1], w_res_next[N-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign bo        = r_bo;
  assign ov        = r_ov;

endmodule

// File: tb/tb_serial_subtract.sv
// Directed self-checking bench for serial_subtract with N=32, K=8.
module tb_serial_subtract;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        bo;
  logic        ov;

  int n_assert = 0;
  int n_fail   = 0;

  serial_subtract #(.N(32), .K(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .bo        (bo),
    .ov        (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one operation, check the 4-cycle latency and in_ready, then check the result.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb, input logic vbi,
                        input logic [31:0] ec, input logic ebo, input logic eov);
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    a = va; b = vb; bi = vbi; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; bi = ~vbi;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk($sformatf("%s.out_valid_c%0d", tag, k), 32'(out_valid), 32'd0);
        chk($sformatf("%s.in_ready_c%0d", tag, k), 32'(in_ready), 32'd0);
      end else begin
        chk({tag, ".out_valid_lat4"}, 32'(out_valid), 32'd1);
      end
    end
    chk({tag, ".c"},  c, ec);
    chk({tag, ".bo"}, 32'(bo), 32'(ebo));
    chk({tag, ".ov"}, 32'(ov), 32'(eov));
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_fall"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bi = 1'b0;
    #12;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.c", c, 32'd0);
    chk("reset.bo", 32'(bo), 32'd0);
    chk("reset.ov", 32'(ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0);
    handoff("basic");
    run_op("neg", 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
    handoff("neg");
    run_op("bi_only", 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    handoff("bi_only");
    run_op("cross8", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0);
    handoff("cross8");
    run_op("cross24", 32'h01000000, 32'h00000001, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0);
    handoff("cross24");
    run_op("ovf_min", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    handoff("ovf_min");
    run_op("ovf_max", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    handoff("ovf_max");

    // Backpressure: result must hold while inputs churn and out_ready stays low.
    run_op("bp", 32'h12345678, 32'h11111111, 1'b0, 32'h01234567, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a = 32'hA5A5_0000 + 32'(k); b = 32'(k * 7); bi = k[1];
      @(posedge clk);
      #1;
      chk($sformatf("bp.out_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp.in_ready_%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp.c_%0d", k), c, 32'h01234567);
      chk($sformatf("bp.bo_ov_%0d", k), {30'd0, bo, ov}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handoff("bp");
    run_op("after_bp", 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1);
    handoff("after_bp");

    // Reset asynchronously between edges in RUN cycle 2.
    @(negedge clk);
    a = 32'd100; b = 32'd1; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid.c", c, 32'd0);
    chk("rst_mid.bo_ov", {30'd0, bo, ov}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0);
    handoff("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtract.md
Name: serial_subtract

Overview:
- Multi-cycle, digit-serial fixed-point subtractor for the FixedPointArithmetic IP, Subtract unit.
- It is the inverse-direction counterpart of the combinational add units: it computes c = a - b - bi.
- Processing is K bits per cycle, least-significant digit first, with a valid/ready handshake on both sides.
- Used where area matters more than latency; fits between operand registers and the result bus of the datapath.

Parameters:
- N, 32, datapath width in bits.
- K, 8, digit width processed per cycle. N % K == 0 is required; elaboration fails otherwise.
- D, N/K (localparam), number of RUN cycles per operation.

Ports:
- clk        input   1  clock, rising edge.
- rst        input   1  reset, asynchronous, active-high.
- in_valid   input   1  operands a, b and bi are valid.
- in_ready   output  1  block can accept operands.
- a          input   N  minuend.
- b          input   N  subtrahend.
- bi         input   1  borrow in.
- out_valid  output  1  c, bo and ov are valid.
- out_ready  input   1  consumer accepts the result.
- c          output  N  difference, a - b - bi mod 2^N.
- bo         output  1  borrow out; 1 iff unsigned a < b + bi.
- ov         output  1  signed (two's complement) overflow.

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset values:
  - state=IDLE, so in_ready=1 and out_valid=0.
  - c=0, bo=0, ov=0.
  - Internal operand registers, digit counter and borrow register all cleared.
- IDLE: on in_valid && in_ready at an edge, capture a, b and bi (bi into the borrow register), clear digit index to 0, go to RUN.
- RUN: each cycle, digit i computes {borrow', d} = a[i] - b[i] - borrow (K+1 bits).
  - d is written to result digit i; borrow is updated to borrow'.
  - The index increments.
  - After digit D-1, go to DONE. In the same edge, load c, bo = final borrow and ov.
- Overflow rule: ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]), using the captured operands.
- Latency: out_valid rises exactly D cycles after the accepting edge. With defaults, it is asserted 4 cycles after acceptance.
- DONE: c, bo and ov are held stable while out_valid=1 && out_ready=0, with no limit on duration. On out_ready=1, go to IDLE; out_valid falls the next cycle.
- Throughput: one operation per D+2 cycles minimum (accept, D RUN cycles, handoff). There is no accept in DONE.
- Outputs c, bo and ov are registered and change only on the RUN→DONE edge. They retain the last result in IDLE and RUN.
- in_valid outside IDLE is ignored. Operand inputs may change freely after acceptance.
- out_ready outside DONE is ignored.
- Reset asserted in any state (including mid-RUN or DONE) immediately forces the reset values; any in-flight operation is discarded.
- Wrap-around: c is the result modulo 2^N. No saturation.

Decomposition:
- Shared package fixed_point_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t.
  - Helper function for the signed-overflow rule, shared with future add/sub units.
- One sub-module: digit_subtract. It is a combinational K-bit subtractor (a, b, bi → d, bo), instantiated once and reused each RUN cycle.
- The digit index counter width is $clog2(D), minimum 1.

Test Plan (N=32, K=8):
- a=5, b=3, bi=0 → c=0x00000002, bo=0, ov=0. out_valid exactly 4 cycles after the accepting edge; in_ready=0 throughout.
- a=3, b=5, bi=0 → c=0xFFFFFFFE, bo=1, ov=0. Then a=0, b=0, bi=1 → c=0xFFFFFFFF, bo=1, ov=0.
- a=0x00000100, b=0x00000001 (borrow crosses digit boundary) → c=0x000000FF, bo=0. Also a=0x01000000, b=1 → c=0x00FFFFFF.
- Signed overflow:
  - a=0x80000000, b=1 → c=0x7FFFFFFF, bo=0, ov=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF → c=0x80000000, bo=1, ov=1.
- Backpressure: hold out_ready=0 for 10 cycles while toggling in_valid and operands. out_valid, c, bo and ov stay constant and in_ready stays 0. After out_ready=1, IDLE follows and the next operation runs correctly.
- Reset mid-operation: assert rst asynchronously (between edges) in RUN cycle 2. out_valid=0, in_ready=1, and c/bo/ov=0 appear immediately. After release, a=10, b=4 → c=6 with 4-cycle latency.
